// File: rtl/bcd2binary_if.sv
// Request/result bundle for the BCD-to-binary converter.
// The master side issues start/bcd_in; the slave side returns the registered result and status.
interface bcd2binary_if #(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
);
    logic                  start;
    logic [4*DIGITS-1:0]   bcd_in;
    logic [BIN_W-1:0]      bin;
    logic                  busy;
    logic                  done;
    logic                  err;

    modport master (output start, bcd_in, input bin, busy, done, err);
    modport slave  (input start, bcd_in, output bin, busy, done, err);
endinterface

// File: rtl/bcd2binary.sv
// Iterative packed-BCD to binary converter using reverse double-dabble:
// one shift-right-and-adjust step per clock, start/busy/done handshake, invalid-digit flag.
module bcd2binary #(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
) (
    input  logic         clk,
    input  logic         reset,
    bcd2binary_if.slave  bus
);
    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W);

    typedef enum logic [0:0] {IDLE = 1'b0, CONVERT = 1'b1} state_t;

    function automatic logic has_bad_digit(input logic [BCD_W-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            bad = bad | (v[4*i +: 4] > 4'd9);
        end
        return bad;
    endfunction

    // Undo the "+3" of forward double-dabble on every nibble that crossed 8 after the shift
    function automatic logic [BCD_W-1:0] adjust_nibbles(input logic [BCD_W-1:0] v);
        logic [BCD_W-1:0] r;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = (v[4*i +: 4] >= 4'd8) ? (v[4*i +: 4] - 4'd3) : v[4*i +: 4];
        end
        return r;
    endfunction

    state_t             state_r, state_nxt_s;
    logic [BCD_W-1:0]   w_r, w_nxt_s;
    logic [BIN_W-1:0]   b_r, b_nxt_s;
    logic [CNT_W-1:0]   cnt_r, cnt_nxt_s;
    logic [BIN_W-1:0]   bin_r, bin_nxt_s;
    logic               busy_r, busy_nxt_s;
    logic               done_r, done_nxt_s;
    logic               err_r, err_nxt_s;
    logic               rej_r, rej_nxt_s;
    logic [BCD_W+BIN_W-1:0] shifted_s;

    assign shifted_s = {1'b0, w_r, b_r[BIN_W-1:1]};

    // Next-state and datapath update for the IDLE/CONVERT machine
    always_comb begin
        state_nxt_s = state_r;
        w_nxt_s     = w_r;
        b_nxt_s     = b_r;
        cnt_nxt_s   = cnt_r;
        bin_nxt_s   = bin_r;
        busy_nxt_s  = busy_r;
        done_nxt_s  = 1'b0;
        err_nxt_s   = err_r;
        rej_nxt_s   = 1'b0;
        case (state_r)
            IDLE: begin
                // A rejected request owns the following cycle to deliver its done pulse
                if (rej_r) begin
                    done_nxt_s = 1'b1;
                end else if (bus.start) begin
                    w_nxt_s   = bus.bcd_in;
                    b_nxt_s   = '0;
                    cnt_nxt_s = '0;
                    err_nxt_s = 1'b0;
                    if (has_bad_digit(bus.bcd_in)) begin
                        err_nxt_s = 1'b1;
                        rej_nxt_s = 1'b1;
                    end else begin
                        state_nxt_s = CONVERT;
                        busy_nxt_s  = 1'b1;
                    end
                end else begin
                    busy_nxt_s = 1'b0;
                end
            end
            CONVERT: begin
                w_nxt_s   = adjust_nibbles(shifted_s[BCD_W+BIN_W-1 -: BCD_W]);
                b_nxt_s   = shifted_s[BIN_W-1:0];
                cnt_nxt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                if (cnt_r == CNT_W'(BIN_W - 1)) begin
                    bin_nxt_s   = shifted_s[BIN_W-1:0];
                    done_nxt_s  = 1'b1;
                    busy_nxt_s  = 1'b0;
                    state_nxt_s = IDLE;
                end else begin
                    busy_nxt_s = 1'b1;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                busy_nxt_s  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset taking priority
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            w_r     <= '0;
            b_r     <= '0;
            cnt_r   <= '0;
            bin_r   <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
            rej_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            w_r     <= w_nxt_s;
            b_r     <= b_nxt_s;
            cnt_r   <= cnt_nxt_s;
            bin_r   <= bin_nxt_s;
            busy_r  <= busy_nxt_s;
            done_r  <= done_nxt_s;
            err_r   <= err_nxt_s;
            rej_r   <= rej_nxt_s;
        end
    end

    assign bus.bin  = bin_r;
    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.err  = err_r;
endmodule

// File: tb/tb_bcd2binary.sv
// Scoreboard bench for bcd2binary: stimulus pushes expected results, a negedge monitor pops on done.
module tb_bcd2binary;
    localparam int DIGITS = 4;
    localparam int BIN_W  = 14;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    bcd2binary_if #(.DIGITS(DIGITS), .BIN_W(BIN_W)) bus ();
    bcd2binary #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct {
        int bin;
        int err;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   model_bin   = 0;

    task automatic check(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, act, act, req, req);
        end
    endtask

    function automatic bit ref_bad(input logic [15:0] v);
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic int ref_val(input logic [15:0] v);
        return int'(v[15:12]) * 1000 + int'(v[11:8]) * 100 + int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction

    // Expected outcome of an accepted request: rejection keeps the previous result
    task automatic push_exp(input logic [15:0] v);
        exp_t e;
        if (ref_bad(v)) begin
            e.bin = model_bin;
            e.err = 1;
        end else begin
            model_bin = ref_val(v);
            e.bin = model_bin;
            e.err = 0;
        end
        sb.push_back(e);
    endtask

    task automatic issue(input logic [15:0] v);
        bus.bcd_in = v;
        bus.start  = 1'b1;
        @(posedge clk);
        #1;
        bus.start  = 1'b0;
        bus.bcd_in = 16'($urandom);
        push_exp(v);
    endtask

    task automatic wait_done(output int lat, output int bsy);
        lat = -1;
        bsy = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                lat = n - 1;
                return;
            end
            if (bus.busy === 1'b1) bsy++;
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        exp_t e;
        if (reset === 1'b0 && bus.done === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                e = sb.pop_front();
                check("bin", int'(bus.bin), e.bin);
                check("err", int'(bus.err), e.err);
                check("busy_at_done", int'(bus.busy), 0);
                if (e.err == 0) check("w_drained", int'(dut.w_r), 0);
            end
        end
    end

    initial begin
        int lat, bsy;
        logic [15:0] v;
        logic [15:0] corners [8];
        corners = '{16'h0000, 16'h9999, 16'h0010, 16'h1234, 16'h0009, 16'h9000, 16'h8888, 16'h0990};

        reset = 1'b1;
        bus.start = 1'b0;
        bus.bcd_in = 16'h0000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_bin", int'(bus.bin), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_err", int'(bus.err), 0);
        reset = 1'b0;

        // Zero input: latency and busy width
        @(negedge clk);
        issue(16'h0000);
        wait_done(lat, bsy);
        check("lat_zero", lat, 14);
        check("busy_cycles_zero", bsy, 14);

        foreach (corners[i]) begin
            @(negedge clk);
            issue(corners[i]);
            wait_done(lat, bsy);
            check("lat_corner", lat, 14);
        end

        // Rejection after a 0x04D2 result, then recovery
        @(negedge clk);
        issue(16'h1234);
        wait_done(lat, bsy);
        @(negedge clk);
        issue(16'h12A4);
        wait_done(lat, bsy);
        check("lat_reject", lat, 1);
        check("busy_reject", bsy, 0);
        @(negedge clk);
        issue(16'h0001);
        wait_done(lat, bsy);
        check("lat_after_reject", lat, 14);

        // Start during conversion is ignored; start in the done cycle is accepted
        @(negedge clk);
        issue(16'h0500);
        repeat (4) @(negedge clk);
        bus.bcd_in = 16'h0007;
        bus.start  = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done(lat, bsy);
        check("lat_ignored_start", lat, 10);
        issue(16'h0777);
        wait_done(lat, bsy);
        check("lat_back_to_back", lat, 14);

        // Reset in the middle of a conversion
        @(negedge clk);
        issue(16'h9999);
        repeat (6) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_bin", int'(bus.bin), 0);
        check("midrst_busy", int'(bus.busy), 0);
        check("midrst_done", int'(bus.done), 0);
        check("midrst_err", int'(bus.err), 0);
        sb.delete();
        model_bin = 0;
        reset = 1'b0;
        repeat (20) @(negedge clk);
        issue(16'h0042);
        wait_done(lat, bsy);
        check("lat_after_reset", lat, 14);

        // Start held high: a new conversion every 15 cycles
        @(negedge clk);
        bus.bcd_in = 16'h0042;
        bus.start  = 1'b1;
        for (int k = 0; k < 4; k++) push_exp(16'h0042);
        for (int k = 0; k < 4; k++) begin
            wait_done(lat, bsy);
            check("lat_hold_start", lat, 14);
        end
        bus.start = 1'b0;

        // Random valid values, then raw 16-bit patterns including invalid digits
        for (int i = 0; i < 1500; i++) begin
            v = {4'($urandom_range(9)), 4'($urandom_range(9)), 4'($urandom_range(9)), 4'($urandom_range(9))};
            @(negedge clk);
            issue(v);
            wait_done(lat, bsy);
            check("lat_rand", lat, 14);
        end
        for (int i = 0; i < 200; i++) begin
            v = 16'($urandom);
            @(negedge clk);
            issue(v);
            wait_done(lat, bsy);
            check("lat_raw", lat, ref_bad(v) ? 1 : 14);
        end

        repeat (5) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
